// File: rtl/warp_pkg.sv
// Shared warp-scheduling types and default geometry.
// Used by the scheduler, the instruction buffer, the thread-mask decoder
// consumers and the readiness tracker.
package warp_pkg;

    localparam int DEF_NUM_WARPS        = 4;
    localparam int DEF_THREADS_PER_WARP = 8;
    localparam int WARP_ID_W            = (DEF_NUM_WARPS > 1) ? $clog2(DEF_NUM_WARPS) : 1;

    typedef logic [WARP_ID_W-1:0]            warp_id_t;
    typedef logic [DEF_THREADS_PER_WARP-1:0] thread_mask_t;

endpackage

// File: rtl/warp_stall_counter.sv
// One per-warp saturating stall counter with its starvation compare.
// The starved flag is decoded straight from the counter register, so it
// changes on the same edge as the count.
module warp_stall_counter #(
    parameter int STALL_CNT_W   = 8,
    parameter int STARVE_THRESH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic incr,
    output logic starved
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [STALL_CNT_W-1:0] THRESH_VAL = STALL_CNT_W'(STARVE_THRESH);

    // A threshold above the counter ceiling could never be reached.
    if (STARVE_THRESH > (2 ** STALL_CNT_W) - 1) begin : g_thresh_check
        $error("warp_stall_counter: STARVE_THRESH exceeds the counter maximum");
    end

    logic [STALL_CNT_W-1:0] cnt_q;
    logic [STALL_CNT_W-1:0] cnt_d;

    // Clear beats increment; increment sticks at the maximum instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (incr && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + STALL_CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved = (cnt_q >= THRESH_VAL);

endmodule

// File: rtl/warp_ready_tracker.sv
// Registered warp readiness tracker.
// Owns the per-thread busy bitmap: issues reserve threads and completions
// release them. Readiness is judged against the post-update bitmap, so a
// same-cycle completion unblocks a warp on the very next edge. It also flags
// illegal issues and keeps per-warp stall counters for starvation detection.
module warp_ready_tracker
    import warp_pkg::*;
#(
    parameter int NUM_WARPS        = DEF_NUM_WARPS,
    parameter int THREADS_PER_WARP = DEF_THREADS_PER_WARP,
    parameter int STALL_CNT_W      = 8,
    parameter int STARVE_THRESH    = 16,
    localparam int WID_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int BUSY_W = NUM_WARPS * THREADS_PER_WARP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WARPS-1:0]        instr_valid,
    input  logic [BUSY_W-1:0]           instr_mask,
    input  logic                        issue_valid,
    input  logic [WID_W-1:0]            issue_warp,
    input  logic [THREADS_PER_WARP-1:0] issue_mask,
    input  logic                        cmpl_valid,
    input  logic [WID_W-1:0]            cmpl_warp,
    input  logic [THREADS_PER_WARP-1:0] cmpl_mask,
    output logic [NUM_WARPS-1:0]        ready_warps,
    output logic [NUM_WARPS-1:0]        starved_warps,
    output logic [BUSY_W-1:0]           busy_threads,
    output logic                        issue_err
);

    localparam int TPW = THREADS_PER_WARP;

    logic [BUSY_W-1:0]    busy_q;
    logic [BUSY_W-1:0]    busy_d;
    logic [BUSY_W-1:0]    set_vec;
    logic [BUSY_W-1:0]    clr_vec;
    logic [NUM_WARPS-1:0] ready_q;
    logic [NUM_WARPS-1:0] ready_d;
    logic                 issue_err_q;
    logic                 issue_err_d;
    logic                 issue_in_range;
    logic [NUM_WARPS-1:0] stall_clear;
    logic [NUM_WARPS-1:0] stall_incr;

    // Place the issue/completion masks at their warp slot; out-of-range
    // indices match no slot and leave the bitmap alone. Set wins over clear.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (issue_valid && (issue_warp == WID_W'(w))) begin
                set_vec[w*TPW +: TPW] = issue_mask;
            end
            if (cmpl_valid && (cmpl_warp == WID_W'(w))) begin
                clr_vec[w*TPW +: TPW] = cmpl_mask;
            end
        end
        busy_d = (busy_q & ~clr_vec) | set_vec;
    end

    // A warp is ready when it has a head instruction whose threads are all idle after this cycle's update.
    always_comb begin
        ready_d = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            ready_d[w] = instr_valid[w] &&
                         ((instr_mask[w*TPW +: TPW] & busy_d[w*TPW +: TPW]) == '0);
        end
    end

    // Flag issues to a non-ready warp, onto busy threads, or to a nonexistent warp.
    always_comb begin
        issue_in_range = 1'b0;
        issue_err_d    = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (issue_warp == WID_W'(w)) begin
                issue_in_range = 1'b1;
                if (!ready_q[w] || ((issue_mask & busy_q[w*TPW +: TPW]) != '0)) begin
                    issue_err_d = issue_valid;
                end
            end
        end
        if (issue_valid && !issue_in_range) begin
            issue_err_d = 1'b1;
        end
    end

    // Bitmap, readiness and error registers; reset drops every reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            ready_q     <= '0;
            issue_err_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            issue_err_q <= issue_err_d;
        end
    end

    // Stall counters restart on an issue to the warp or when it has nothing queued, and count while it waits.
    always_comb begin
        stall_clear = '0;
        stall_incr  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            stall_clear[w] = (issue_valid && (issue_warp == WID_W'(w))) || !instr_valid[w];
            stall_incr[w]  = instr_valid[w] && !ready_q[w];
        end
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_stall
        warp_stall_counter #(
            .STALL_CNT_W  (STALL_CNT_W),
            .STARVE_THRESH(STARVE_THRESH)
        ) u_stall_counter (
            .clk    (clk),
            .rst    (rst),
            .clear  (stall_clear[w]),
            .incr   (stall_incr[w]),
            .starved(starved_warps[w])
        );
    end

    assign ready_warps  = ready_q;
    assign busy_threads = busy_q;
    assign issue_err    = issue_err_q;

endmodule

// File: tb/tb_warp_ready_tracker.sv
// Directed vector bench for warp_ready_tracker. A second instance with a
// 4-bit stall counter shares the stimulus to exercise counter saturation.
module tb_warp_ready_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  instr_valid;
    logic [31:0] instr_mask;
    logic        issue_valid;
    logic [1:0]  issue_warp;
    logic [7:0]  issue_mask;
    logic        cmpl_valid;
    logic [1:0]  cmpl_warp;
    logic [7:0]  cmpl_mask;

    logic [3:0]  ready_warps;
    logic [3:0]  starved_warps;
    logic [31:0] busy_threads;
    logic        issue_err;

    logic [3:0]  ready2;
    logic [3:0]  starved2;
    logic [31:0] busy2;
    logic        err2;

    int vectors_applied = 0;
    int miscompares     = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  iv;
        logic [31:0] im;
        logic        isv;
        logic [1:0]  iw;
        logic [7:0]  imk;
        logic        cv;
        logic [1:0]  cw;
        logic [7:0]  cm;
        logic [3:0]  e_ready;
        logic [31:0] e_busy;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    warp_ready_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_mask   (instr_mask),
        .issue_valid  (issue_valid),
        .issue_warp   (issue_warp),
        .issue_mask   (issue_mask),
        .cmpl_valid   (cmpl_valid),
        .cmpl_warp    (cmpl_warp),
        .cmpl_mask    (cmpl_mask),
        .ready_warps  (ready_warps),
        .starved_warps(starved_warps),
        .busy_threads (busy_threads),
        .issue_err    (issue_err)
    );

    warp_ready_tracker #(
        .STALL_CNT_W  (4),
        .STARVE_THRESH(15)
    ) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_mask   (instr_mask),
        .issue_valid  (issue_valid),
        .issue_warp   (issue_warp),
        .issue_mask   (issue_mask),
        .cmpl_valid   (cmpl_valid),
        .cmpl_warp    (cmpl_warp),
        .cmpl_mask    (cmpl_mask),
        .ready_warps  (ready2),
        .starved_warps(starved2),
        .busy_threads (busy2),
        .issue_err    (err2)
    );

    function automatic vec_t makeVec(input string name, input logic r, input logic [3:0] iv,
                                     input logic [31:0] im, input logic isv, input logic [1:0] iw,
                                     input logic [7:0] imk, input logic cv, input logic [1:0] cw,
                                     input logic [7:0] cm, input logic [3:0] e_ready,
                                     input logic [31:0] e_busy, input logic e_err);
        vec_t v;
        v.name = name; v.rst = r; v.iv = iv; v.im = im;
        v.isv = isv; v.iw = iw; v.imk = imk;
        v.cv = cv; v.cw = cw; v.cm = cm;
        v.e_ready = e_ready; v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    // Drive one cycle of inputs, then step past the next rising edge.
    task automatic applyStimulus(input vec_t v);
        rst         = v.rst;
        instr_valid = v.iv;
        instr_mask  = v.im;
        issue_valid = v.isv;
        issue_warp  = v.iw;
        issue_mask  = v.imk;
        cmpl_valid  = v.cv;
        cmpl_warp   = v.cw;
        cmpl_mask   = v.cm;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e_ready, input logic [31:0] e_busy,
                               input logic e_err, input logic [3:0] e_starved, input logic [3:0] e_starved2);
        vectors_applied++;
        if (ready_warps !== e_ready || busy_threads !== e_busy || issue_err !== e_err ||
            starved_warps !== e_starved || ready2 !== e_ready || busy2 !== e_busy ||
            err2 !== e_err || starved2 !== e_starved2) begin
            miscompares++;
            $display("[TB] FAIL %s: got ready=%b busy=%h err=%b starved=%b | sat ready=%b busy=%h err=%b starved=%b ; want ready=%b busy=%h err=%b starved=%b sat_starved=%b",
                     name, ready_warps, busy_threads, issue_err, starved_warps,
                     ready2, busy2, err2, starved2, e_ready, e_busy, e_err, e_starved, e_starved2);
        end
    endtask

    initial begin
        vec_t v;

        rst = 1'b1; instr_valid = '0; instr_mask = '0;
        issue_valid = 1'b0; issue_warp = '0; issue_mask = '0;
        cmpl_valid = 1'b0; cmpl_warp = '0; cmpl_mask = '0;

        //                name            rst iv       im             isv iw  imk    cv cw  cm     ready    busy           err
        vecs.push_back(makeVec("reset0",      1, 4'b1111, 32'hFFFF_FFFF, 0, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 32'h0000_0000, 0));
        vecs.push_back(makeVec("reset1",      1, 4'b1111, 32'hFFFF_FFFF, 0, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 32'h0000_0000, 0));
        vecs.push_back(makeVec("release",     0, 4'b1111, 32'hFFFF_FFFF, 0, 0, 8'h00, 0, 0, 8'h00, 4'b1111, 32'h0000_0000, 0));
        vecs.push_back(makeVec("issue_w1",    0, 4'b1111, 32'h0000_0100, 1, 1, 8'h0F, 0, 0, 8'h00, 4'b1101, 32'h0000_0F00, 0));
        vecs.push_back(makeVec("w1_nooverlap",0, 4'b1111, 32'h0000_F000, 0, 0, 8'h00, 0, 0, 8'h00, 4'b1111, 32'h0000_0F00, 0));
        vecs.push_back(makeVec("issue_w2",    0, 4'b1111, 32'h0000_F000, 1, 2, 8'h03, 0, 0, 8'h00, 4'b1111, 32'h0003_0F00, 0));
        vecs.push_back(makeVec("set_wins",    0, 4'b1111, 32'h0000_F000, 1, 2, 8'h02, 1, 2, 8'h03, 4'b1111, 32'h0002_0F00, 1));
        vecs.push_back(makeVec("err_pulse",   0, 4'b1111, 32'h0000_F000, 0, 0, 8'h00, 0, 0, 8'h00, 4'b1111, 32'h0002_0F00, 0));
        vecs.push_back(makeVec("issue_w0",    0, 4'b1111, 32'h0000_F080, 1, 0, 8'h80, 0, 0, 8'h00, 4'b1110, 32'h0002_0F80, 0));
        vecs.push_back(makeVec("w0_blocked",  0, 4'b1111, 32'h0000_F080, 0, 0, 8'h00, 0, 0, 8'h00, 4'b1110, 32'h0002_0F80, 0));
        vecs.push_back(makeVec("cmpl_w0",     0, 4'b1111, 32'h0000_F080, 0, 0, 8'h00, 1, 0, 8'h80, 4'b1111, 32'h0002_0F00, 0));
        vecs.push_back(makeVec("cmpl_idle",   0, 4'b1111, 32'h0000_F080, 0, 0, 8'h00, 1, 3, 8'hFF, 4'b1111, 32'h0002_0F00, 0));
        vecs.push_back(makeVec("w3_invalid",  0, 4'b0111, 32'h0000_F080, 0, 0, 8'h00, 0, 0, 8'h00, 4'b0111, 32'h0002_0F00, 0));
        vecs.push_back(makeVec("illegal_w3",  0, 4'b0111, 32'h0000_F080, 1, 3, 8'h3C, 0, 0, 8'h00, 4'b0111, 32'h3C02_0F00, 1));
        vecs.push_back(makeVec("after_ill",   0, 4'b1111, 32'h0000_F080, 0, 0, 8'h00, 0, 0, 8'h00, 4'b1111, 32'h3C02_0F00, 0));
        vecs.push_back(makeVec("cmpl_w1",     0, 4'b1111, 32'h0000_F080, 0, 0, 8'h00, 1, 1, 8'h0F, 4'b1111, 32'h3C02_0000, 0));
        vecs.push_back(makeVec("mid_reset",   1, 4'b1111, 32'hFFFF_FFFF, 0, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 32'h0000_0000, 0));
        vecs.push_back(makeVec("post_reset",  0, 4'b1111, 32'hFFFF_FFFF, 0, 0, 8'h00, 0, 0, 8'h00, 4'b1111, 32'h0000_0000, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, vecs[i].e_ready, vecs[i].e_busy, vecs[i].e_err, 4'b0000, 4'b0000);
        end

        // Starvation and saturation: warp 0 blocked on its own reservation.
        v = makeVec("stv_reset", 1, 4'b0001, 32'h0, 0, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 32'h0, 0);
        applyStimulus(v);
        checkOutput(v.name, 4'b0000, 32'h0, 1'b0, 4'b0000, 4'b0000);

        v = makeVec("stv_idle", 0, 4'b0001, 32'h0, 0, 0, 8'h00, 0, 0, 8'h00, 4'b0001, 32'h0, 0);
        applyStimulus(v);
        checkOutput(v.name, 4'b0001, 32'h0, 1'b0, 4'b0000, 4'b0000);

        v = makeVec("stv_block", 0, 4'b0001, 32'h80, 1, 0, 8'h80, 0, 0, 8'h00, 4'b0000, 32'h80, 0);
        applyStimulus(v);
        checkOutput(v.name, 4'b0000, 32'h80, 1'b0, 4'b0000, 4'b0000);

        for (int k = 1; k <= 40; k++) begin
            v = makeVec("stv_wait", 0, 4'b0001, 32'h80, 0, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 32'h80, 0);
            applyStimulus(v);
            checkOutput($sformatf("stv_wait_%0d", k), 4'b0000, 32'h80, 1'b0,
                        {3'b000, (k >= 16)}, {3'b000, (k >= 15)});
        end

        v = makeVec("stv_issue", 0, 4'b0001, 32'h80, 1, 0, 8'h01, 0, 0, 8'h00, 4'b0000, 32'h81, 1);
        applyStimulus(v);
        checkOutput(v.name, 4'b0000, 32'h81, 1'b1, 4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
